// File: rtl/norm_check_mem_reader_pkg.sv
// ---------------------------------------------------------------------------
// norm_check_mem_reader_pkg
// Shared definitions for the norm-check datapath: check modes, the memory
// reader FSM states, word/coefficient geometry, and a helper that turns a
// polynomial count into a word count.
// ---------------------------------------------------------------------------
package norm_check_mem_reader_pkg;

   localparam int NC_WORDS_PER_POLY = 64;
   localparam int NC_COEFF_PER_WORD = 4;
   // 15 polynomials * 64 words = 960 words, fits in 10 bits.
   localparam int NC_WORD_CNT_WIDTH = 10;

   typedef enum logic [1:0] {
      CHK_Z_BOUND   = 2'd0,
      CHK_R0_BOUND  = 2'd1,
      CHK_CT0_BOUND = 2'd2
   } chk_norm_mode_t;

   typedef enum logic [1:0] {
      CHK_IDLE   = 2'd0,
      CHK_RD_MEM = 2'd1,
      CHK_WAIT   = 2'd2,
      CHK_DONE   = 2'd3
   } chk_read_state_e;

   // Total words for a run: num_poly * 64.
   function automatic logic [NC_WORD_CNT_WIDTH-1:0] nc_total_words(input logic [3:0] num_poly);
      return {num_poly, 6'd0};
   endfunction

endpackage

// File: rtl/norm_check_rd_fifo.sv
// ---------------------------------------------------------------------------
// norm_check_rd_fifo
// Two-entry FIFO with a registered head. Entry 0 (r_head) drives o_data
// directly, entry 1 (r_tail) holds the next word. Simultaneous push and pop
// keeps the count unchanged. The caller guarantees no push when full and no
// pop when empty.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   i_clear       synchronous clear (same effect as reset)
//   i_push/i_data write one entry
//   i_pop         remove the head entry
//   o_data        head entry (stable until popped)
//   o_count       occupancy, 0..2
// ---------------------------------------------------------------------------
module norm_check_rd_fifo #(
   parameter int WIDTH = 98
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic [1:0]       r_count;

   // NOTE: the two storage entries are reset along with the count because
   // the head register is a module output that must read zero after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else if (i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else begin
         unique case ({i_push, i_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= i_data;
               else                 r_tail <= i_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // With one entry the new word goes straight to the head;
               // with two, the tail advances and the new word refills it.
               if (r_count == 2'd1) begin
                  r_head <= i_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_data  = r_head;
   assign o_count = r_count;

endmodule

// File: rtl/norm_check_mem_reader.sv
// ---------------------------------------------------------------------------
// norm_check_mem_reader
// Walks num_poly*64 consecutive SRAM words starting at base_addr (wrapping
// modulo 2^MEM_ADDR_WIDTH), one read per cycle, and streams each 4-coefficient
// word to the norm checker over valid/ready. A 2-entry FIFO plus read-credit
// accounting absorbs backpressure. Each word carries the latched mode and
// per-polynomial / final last markers.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   zeroize                 synchronous clear, same effect as reset
//   enable                  start pulse (sampled only when idle)
//   mode, base_addr,        run parameters, latched on start
//   num_poly
//   mem_rd_en, mem_rd_addr  SRAM read request
//   mem_rd_data             SRAM data, valid the cycle after mem_rd_en
//   coeff_valid/ready/data  output word stream, coefficient 0 in LSBs
//   coeff_mode              latched check mode
//   coeff_poly_last         word 63 of a polynomial
//   coeff_last              final word of the run
//   busy, done              FSM not idle / one-cycle end-of-run pulse
// ---------------------------------------------------------------------------
module norm_check_mem_reader
   import norm_check_mem_reader_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 15,
   parameter int COEFF_WIDTH    = 24,
   parameter int COEFF_PER_WORD = NC_COEFF_PER_WORD,
   parameter int MEM_DATA_WIDTH = COEFF_PER_WORD * COEFF_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      zeroize,
   input  logic                      enable,
   input  logic [1:0]                mode,
   input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
   input  logic [3:0]                num_poly,
   output logic                      mem_rd_en,
   output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
   output logic                      coeff_valid,
   input  logic                      coeff_ready,
   output logic [MEM_DATA_WIDTH-1:0] coeff_data,
   output logic [1:0]                coeff_mode,
   output logic                      coeff_poly_last,
   output logic                      coeff_last,
   output logic                      busy,
   output logic                      done
);

   localparam int CW = NC_WORD_CNT_WIDTH;

   chk_read_state_e           r_state;
   chk_read_state_e           w_next_state;
   chk_norm_mode_t            r_mode;
   logic [MEM_ADDR_WIDTH-1:0] r_base;
   logic [CW-1:0]             r_total;
   logic [CW-1:0]             r_word_cnt;
   logic                      r_inflight;
   logic                      r_sb_poly_last;
   logic                      r_sb_last;

   logic                      w_start;
   logic                      w_pop;
   logic                      w_issue;
   logic                      w_last_issue;
   logic [2:0]                w_credit;
   logic [1:0]                w_fifo_count;
   logic [MEM_DATA_WIDTH+1:0] w_fifo_dout;

   assign w_start = (r_state == CHK_IDLE) && enable;
   assign w_pop   = coeff_valid && coeff_ready;

   // Occupancy the FIFO will have after this edge: words held, plus the word
   // returning from the SRAM now, minus the word leaving now. A read issued
   // this cycle lands one edge later, so issuing is safe while that is < 2.
   assign w_credit     = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue      = (r_state == CHK_RD_MEM) && (w_credit < 3'd2);
   assign w_last_issue = w_issue && (r_word_cnt == r_total - CW'(1));

   // NOTE: state and all datapath registers use non-blocking assignments so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     r_state <= CHK_IDLE;
      else if (zeroize) r_state <= CHK_IDLE;
      else              r_state <= w_next_state;
   end

   // NOTE: next-state is defaulted to the current state before the case so
   // no path through this block leaves it unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         CHK_IDLE: begin
            if (enable) w_next_state = (num_poly == 4'd0) ? CHK_DONE : CHK_RD_MEM;
         end
         CHK_RD_MEM: begin
            if (w_last_issue) w_next_state = CHK_WAIT;
         end
         CHK_WAIT: begin
            // Leave as the final handshake completes so done lands the cycle
            // after the last coeff_valid, never alongside it.
            if (!r_inflight &&
                ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop)))
               w_next_state = CHK_DONE;
         end
         CHK_DONE: w_next_state = CHK_IDLE;
         default:  w_next_state = CHK_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode         <= CHK_Z_BOUND;
         r_base         <= '0;
         r_total        <= '0;
         r_word_cnt     <= '0;
         r_inflight     <= 1'b0;
         r_sb_poly_last <= 1'b0;
         r_sb_last      <= 1'b0;
      end else if (zeroize) begin
         r_mode         <= CHK_Z_BOUND;
         r_base         <= '0;
         r_total        <= '0;
         r_word_cnt     <= '0;
         r_inflight     <= 1'b0;
         r_sb_poly_last <= 1'b0;
         r_sb_last      <= 1'b0;
      end else begin
         if (w_start) begin
            r_mode     <= chk_norm_mode_t'(mode);
            r_base     <= base_addr;
            r_total    <= nc_total_words(num_poly);
            r_word_cnt <= '0;
         end else if (w_issue) begin
            r_word_cnt <= r_word_cnt + CW'(1);
         end
         // Sideband pipe: aligned with mem_rd_data one cycle after the read.
         r_inflight     <= w_issue;
         r_sb_poly_last <= w_issue && (r_word_cnt[5:0] == 6'(NC_WORDS_PER_POLY - 1));
         r_sb_last      <= w_last_issue;
      end
   end

   norm_check_rd_fifo #(
      .WIDTH (MEM_DATA_WIDTH + 2)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clear (zeroize),
      .i_push  (r_inflight),
      .i_data  ({r_sb_last, r_sb_poly_last, mem_rd_data}),
      .i_pop   (w_pop),
      .o_data  (w_fifo_dout),
      .o_count (w_fifo_count)
   );

   assign mem_rd_en       = w_issue;
   assign mem_rd_addr     = r_base + MEM_ADDR_WIDTH'(r_word_cnt);
   assign coeff_valid     = (w_fifo_count != 2'd0);
   assign coeff_data      = w_fifo_dout[MEM_DATA_WIDTH-1:0];
   // Markers are qualified so a stale head never shows a marker while idle.
   assign coeff_poly_last = coeff_valid && w_fifo_dout[MEM_DATA_WIDTH];
   assign coeff_last      = coeff_valid && w_fifo_dout[MEM_DATA_WIDTH+1];
   assign coeff_mode      = r_mode;
   assign busy            = (r_state != CHK_IDLE);
   assign done            = (r_state == CHK_DONE);

endmodule

// File: tb/tb_norm_check_mem_reader.sv
// ---------------------------------------------------------------------------
// tb_norm_check_mem_reader
// Scoreboard bench: each launched run pushes its expected read addresses and
// output words (computed from base, num_poly and an SRAM content function);
// a monitor on the opposite clock edge pops and compares as the DUT reads and
// hands off words. Cycle numbers are relative to the edge that samples enable
// (the first cycle after that edge is cycle 1).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_norm_check_mem_reader;

   localparam int AW = 15;
   localparam int DW = 96;

   typedef struct {
      logic [DW-1:0] data;
      logic          poly_last;
      logic          last;
      logic [1:0]    mode;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          zeroize = 1'b0;
   logic          enable = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [AW-1:0] base_addr = '0;
   logic [3:0]    num_poly = 4'd0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic          coeff_valid;
   logic          coeff_ready = 1'b0;
   logic [DW-1:0] coeff_data;
   logic [1:0]    coeff_mode;
   logic          coeff_poly_last;
   logic          coeff_last;
   logic          busy;
   logic          done;

   norm_check_mem_reader dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .zeroize         (zeroize),
      .enable          (enable),
      .mode            (mode),
      .base_addr       (base_addr),
      .num_poly        (num_poly),
      .mem_rd_en       (mem_rd_en),
      .mem_rd_addr     (mem_rd_addr),
      .mem_rd_data     (mem_rd_data),
      .coeff_valid     (coeff_valid),
      .coeff_ready     (coeff_ready),
      .coeff_data      (coeff_data),
      .coeff_mode      (coeff_mode),
      .coeff_poly_last (coeff_poly_last),
      .coeff_last      (coeff_last),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // SRAM contents: a deterministic scramble of the address.
   logic [31:0] mem_seed;
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      logic [31:0] x;
      x = ({17'd0, a} * 32'h9E3779B1) ^ mem_seed;
      return {x ^ 32'h5A5A1234, x + 32'd7, ~x};
   endfunction

   // 1-cycle read latency SRAM model.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);
   end

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   // Sink readiness: 0 always, 1 pattern 1-0-0-1, 2 random, 3 never.
   int ready_mode = 0;
   int pat_i = 0;
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0: coeff_ready = 1'b1;
         1: begin
            coeff_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
            pat_i++;
         end
         2: coeff_ready = 1'($urandom_range(0, 1));
         default: coeff_ready = 1'b0;
      endcase
   end

   exp_t          exp_q[$];
   logic [AW-1:0] addr_q[$];

   // Run statistics (relative cycle numbers, -1 = not seen).
   int            start_e = 0;
   int            n_rd = 0, n_hs = 0, n_pl = 0, n_last = 0;
   int            first_rd = -1, last_rd = -1, first_valid = -1, last_valid = -1;
   int            done_cycle = -1, busy_fall = -1, n_valid = 0;
   logic [AW-1:0] last_rd_addr = '0;
   logic          done_seen = 1'b0, was_busy = 1'b0, done_prev = 1'b0;
   logic          stall_prev = 1'b0;
   logic [DW+1:0] prev_word = '0;

   always @(negedge clk) begin
      int   rel;
      exp_t e;
      rel = ecnt - start_e;
      if (reset_n) begin
         if (mem_rd_en) begin
            n_rd++;
            if (first_rd < 0) first_rd = rel;
            last_rd = rel;
            last_rd_addr = mem_rd_addr;
            if (addr_q.size() == 0) check("unexpected_rd", mem_rd_en, 1'b0);
            else                    check("rd_addr", mem_rd_addr, addr_q.pop_front());
            check("outstanding_le3", (n_rd - n_hs) <= 3, 1'b1);
         end
         if (done) begin
            done_seen  = 1'b1;
            done_cycle = rel;
            check("done_without_valid", coeff_valid, 1'b0);
            check("done_single_pulse", done_prev, 1'b0);
         end
         if (stall_prev) begin
            check("stall_valid_held", coeff_valid, 1'b1);
            check("stall_word_held", {coeff_last, coeff_poly_last, coeff_data}, prev_word);
         end
         if (coeff_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = rel;
            last_valid = rel;
         end
         if (coeff_valid && coeff_ready) begin
            n_hs++;
            if (coeff_poly_last) n_pl++;
            if (coeff_last) n_last++;
            if (exp_q.size() == 0) begin
               check("unexpected_word", coeff_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("coeff_data", coeff_data, e.data);
               check("coeff_poly_last", coeff_poly_last, e.poly_last);
               check("coeff_last", coeff_last, e.last);
               check("coeff_mode", coeff_mode, e.mode);
            end
         end
         stall_prev = coeff_valid && !coeff_ready && !zeroize;
         prev_word  = {coeff_last, coeff_poly_last, coeff_data};
         done_prev  = done;
         if (busy) was_busy = 1'b1;
         else if (was_busy) begin
            busy_fall = rel;
            was_busy  = 1'b0;
         end
      end
   end

   // Issue a start pulse and push the expected behaviour of the whole run.
   task automatic launch(input int np, input logic [AW-1:0] base, input logic [1:0] md);
      int   w;
      exp_t e;
      w = np * 64;
      for (int i = 0; i < w; i++) begin
         addr_q.push_back(AW'(base + AW'(i)));
         e.data      = mem_word(AW'(base + AW'(i)));
         e.poly_last = ((i % 64) == 63);
         e.last      = (i == w - 1);
         e.mode      = md;
         exp_q.push_back(e);
      end
      n_rd = 0; n_hs = 0; n_pl = 0; n_last = 0; n_valid = 0;
      first_rd = -1; last_rd = -1; first_valid = -1; last_valid = -1;
      done_cycle = -1; busy_fall = -1; done_seen = 1'b0;
      start_e   = ecnt;
      enable    = 1'b1;
      num_poly  = 4'(np);
      base_addr = base;
      mode      = md;
      @(posedge clk); #2;
      // Scramble the run inputs: the DUT must be using its latched copies.
      enable    = 1'b0;
      num_poly  = 4'($urandom_range(0, 15));
      base_addr = AW'($urandom);
      mode      = 2'($urandom_range(0, 2));
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         if (done_seen) break;
      end
      check("done_reached", done_seen, 1'b1);
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic check_end_of_run(input string tag, input int np);
      check({tag, "_reads"}, n_rd, np * 64);
      check({tag, "_words"}, n_hs, np * 64);
      check({tag, "_poly_last_cnt"}, n_pl, np);
      check({tag, "_last_cnt"}, n_last, 1);
      check({tag, "_exp_q_empty"}, exp_q.size(), 0);
      check({tag, "_busy_low"}, busy, 1'b0);
   endtask

   initial begin
      mem_seed = $urandom;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_outputs",
            {mem_rd_en, mem_rd_addr, coeff_valid, coeff_data, coeff_mode,
             coeff_poly_last, coeff_last, busy, done}, '0);
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_valid", coeff_valid, 1'b0);
      @(posedge clk); #2;

      // One polynomial, always-ready sink: exact latencies.
      ready_mode = 0;
      launch(1, 15'h0100, 2'd1);
      wait_done(300);
      check("t1_first_rd_cycle", first_rd, 1);
      check("t1_last_rd_cycle", last_rd, 64);
      check("t1_first_valid_cycle", first_valid, 3);
      check("t1_last_valid_cycle", last_valid, 66);
      check("t1_done_cycle", done_cycle, 67);
      check("t1_busy_fall_cycle", busy_fall, 68);
      check("t1_last_addr", last_rd_addr, 15'h013F);
      check_end_of_run("t1", 1);

      // Seven polynomials, z_bound, sink pattern 1-0-0-1.
      ready_mode = 1;
      pat_i      = 0;
      launch(7, AW'($urandom), 2'd0);
      wait_done(3000);
      check_end_of_run("t2", 7);

      // Address wrap.
      ready_mode = 2;
      launch(1, 15'h7FF0, 2'd2);
      wait_done(500);
      check("t3_wrap_last_addr", last_rd_addr, 15'h002F);
      check_end_of_run("t3", 1);

      // Empty run: IDLE goes straight to DONE, so the pulse is immediate.
      ready_mode = 0;
      launch(0, 15'h0200, 2'd1);
      wait_done(20);
      check("t4_done_cycle_le2", (done_cycle >= 1) && (done_cycle <= 2), 1'b1);
      check("t4_no_reads", n_rd, 0);
      check("t4_no_valid", n_valid, 0);

      // Zeroize mid-run while stalled, then restart from a new base.
      ready_mode = 0;
      launch(2, 15'h2345, 2'd2);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #2;
         if (n_hs >= 30) break;
      end
      check("t5_reached_word30", n_hs >= 30, 1'b1);
      ready_mode = 3;
      repeat (4) @(posedge clk);
      #2;
      zeroize = 1'b1;
      @(posedge clk); #2;
      zeroize = 1'b0;
      exp_q.delete();
      addr_q.delete();
      @(negedge clk);
      check("t5_zero_outputs",
            {mem_rd_en, mem_rd_addr, coeff_valid, coeff_data, coeff_mode,
             coeff_poly_last, coeff_last, busy, done}, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_dropped_returns", {coeff_valid, busy, mem_rd_en}, 3'b000);
      end
      @(posedge clk); #2;
      ready_mode = 2;
      launch(1, 15'h0555, 2'd1);
      wait_done(500);
      check("t5_restart_last_addr", last_rd_addr, 15'h0555 + 15'h003F);
      check_end_of_run("t5r", 1);

      // enable pulsed mid-run with different parameters is ignored.
      ready_mode = 2;
      launch(2, 15'h1000, 2'd1);
      repeat (40) @(posedge clk);
      #2;
      enable    = 1'b1;
      mode      = 2'd2;
      base_addr = 15'h6000;
      num_poly  = 4'd5;
      @(posedge clk); #2;
      enable = 1'b0;
      wait_done(1500);
      check_end_of_run("t6", 2);
      repeat (5) @(posedge clk);
      #2;
      check("t6_no_restart_reads", n_rd, 128);
      check("t6_still_idle", busy, 1'b0);

      // A few random runs.
      for (int r = 0; r < 3; r++) begin
         int np;
         np = $urandom_range(1, 3);
         ready_mode = 2;
         launch(np, AW'($urandom), 2'($urandom_range(0, 2)));
         wait_done(2000);
         check_end_of_run("rand", np);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
